// File: rtl/ps2_matrix_mapper.sv
// PS/2 byte stream to ROWS x COLS key-matrix emulator with a runtime-writable scancode map.
// Optional build macro: PS2_MATRIX_GHOST_EN adds diode-less matrix ghosting on col_n.
module ps2_matrix_mapper #(
  parameter int ROWS        = 12,
  parameter int COLS        = 7,
  parameter int ROW_W       = 4,
  parameter int COL_W       = 3,
  parameter int PAUSE_PULSE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_error,
  input  logic                   map_we,
  input  logic [8:0]             map_addr,
  input  logic [ROW_W+COL_W:0]   map_wdata,
  input  logic [ROWS-1:0]        row_sel_n,
  output logic [COLS-1:0]        col_n,
  output logic                   reset_key,
  output logic                   evt_valid,
  output logic                   evt_make,
  output logic [ROW_W-1:0]       evt_row,
  output logic [COL_W-1:0]       evt_col
);

  localparam int ENTRY_W = 1 + ROW_W + COL_W;
  localparam int PCNT_W  = $clog2(PAUSE_PULSE + 1);
  localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PAUSE_PULSE - 1);
  localparam logic [ROW_W:0]    ROWS_LIM  = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0]    COLS_LIM  = (COL_W + 1)'(COLS);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_PAUSE = 1'b1
  } state_e;

  state_e                       state_q;
  logic                         ext_q;
  logic                         rel_q;
  logic [2:0]                   skip_q;
  logic [PCNT_W-1:0]            pcnt_q;
  logic                         reset_key_q;
  logic                         look_valid_q;
  logic                         look_rel_q;
  logic [ENTRY_W-1:0]           look_entry_q;
  logic [ENTRY_W-1:0]           table_mem [0:511];
  logic [ROWS-1:0][COLS-1:0]    matrix_q;
  logic [ROWS-1:0][COLS-1:0]    eff_s;
  logic                         evt_valid_q;
  logic                         evt_make_q;
  logic [ROW_W-1:0]             evt_row_q;
  logic [COL_W-1:0]             evt_col_q;

  logic                         idle_byte_s;
  logic                         is_e0_s;
  logic                         is_f0_s;
  logic                         is_e1_s;
  logic                         is_bat_s;
  logic                         lookup_s;
  logic                         pause_start_s;
  logic                         clear_all_s;
  logic                         entry_valid_s;
  logic [ROW_W-1:0]             entry_row_s;
  logic [COL_W-1:0]             entry_col_s;
  logic                         entry_ok_s;
  logic [COLS-1:0]              col_or_s;

  // Classify the incoming byte; an error strobe outranks a simultaneous byte.
  always_comb begin
    is_e0_s  = 1'b0;
    is_f0_s  = 1'b0;
    is_e1_s  = 1'b0;
    is_bat_s = 1'b0;
    case (rx_data)
      8'hE0:                is_e0_s  = 1'b1;
      8'hF0:                is_f0_s  = 1'b1;
      8'hE1:                is_e1_s  = 1'b1;
      8'hAA, 8'h00, 8'hFF:  is_bat_s = 1'b1;
      default:              is_e0_s  = 1'b0;
    endcase
    idle_byte_s   = rx_valid & ~rx_error & (state_q == S_IDLE);
    pause_start_s = idle_byte_s & is_e1_s;
    lookup_s      = idle_byte_s & ~(is_e0_s | is_f0_s | is_e1_s | is_bat_s);
    clear_all_s   = rx_error | (idle_byte_s & is_bat_s);
  end

  // Decode the table entry fetched in the previous cycle.
  always_comb begin
    entry_valid_s = look_entry_q[ENTRY_W-1];
    entry_row_s   = look_entry_q[ROW_W+COL_W-1:COL_W];
    entry_col_s   = look_entry_q[COL_W-1:0];
    entry_ok_s    = look_valid_q & entry_valid_s &
                    ({1'b0, entry_row_s} < ROWS_LIM) &
                    ({1'b0, entry_col_s} < COLS_LIM);
  end

  // Parser FSM, prefix flags, Pause skip counter, reset_key pulse and lookup pipe stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      skip_q       <= 3'd0;
      pcnt_q       <= '0;
      reset_key_q  <= 1'b0;
      look_valid_q <= 1'b0;
      look_rel_q   <= 1'b0;
    end else begin
      if (pause_start_s) begin
        pcnt_q      <= PCNT_LOAD;
        reset_key_q <= 1'b1;
      end else if (pcnt_q != '0) begin
        pcnt_q      <= pcnt_q - PCNT_W'(1);
      end else begin
        reset_key_q <= 1'b0;
      end

      look_valid_q <= lookup_s;
      look_rel_q   <= rel_q;

      if (rx_error) begin
        state_q <= S_IDLE;
        ext_q   <= 1'b0;
        rel_q   <= 1'b0;
        skip_q  <= 3'd0;
      end else if (rx_valid) begin
        case (state_q)
          S_IDLE: begin
            if (is_e0_s) begin
              ext_q <= 1'b1;
            end else if (is_f0_s) begin
              rel_q <= 1'b1;
            end else if (is_e1_s) begin
              state_q <= S_PAUSE;
              skip_q  <= 3'd7;
            end else begin
              ext_q <= 1'b0;
              rel_q <= 1'b0;
            end
          end
          S_PAUSE: begin
            skip_q <= skip_q - 3'd1;
            if (skip_q == 3'd1) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Mapping RAM: read-before-write, so a same-cycle write is not seen by the lookup.
  always_ff @(posedge clk) begin
    if (map_we) begin
      table_mem[map_addr] <= map_wdata;
    end
    look_entry_q <= table_mem[{ext_q, rx_data}];
  end

  // Key matrix and event strobe; clear-all wins over a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      matrix_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_make_q  <= 1'b0;
      evt_row_q   <= '0;
      evt_col_q   <= '0;
    end else begin
      evt_valid_q <= 1'b0;
      if (clear_all_s) begin
        matrix_q <= '0;
      end else if (entry_ok_s) begin
        matrix_q[entry_row_s][entry_col_s] <= ~look_rel_q;
        evt_valid_q <= 1'b1;
        evt_make_q  <= ~look_rel_q;
        evt_row_q   <= entry_row_s;
        evt_col_q   <= entry_col_s;
      end
    end
  end

`ifdef PS2_MATRIX_GHOST_EN
  // A key also reads as pressed when three pressed keys close a rectangle with it.
  always_comb begin
    eff_s = matrix_q;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        for (int r2 = 0; r2 < ROWS; r2++) begin
          for (int c2 = 0; c2 < COLS; c2++) begin
            eff_s[r][c] = eff_s[r][c] |
                          ((r2 != r) && (c2 != c) && matrix_q[r][c2] &&
                           matrix_q[r2][c2] && matrix_q[r2][c]);
          end
        end
      end
    end
  end
`else
  // Without ghosting the CPU sees the true key state.
  always_comb begin
    eff_s = matrix_q;
  end
`endif

  // Wired-AND column read: any selected row with a pressed key pulls its column low.
  always_comb begin
    col_or_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      col_or_s = col_or_s | (eff_s[r] & {COLS{~row_sel_n[r]}});
    end
    col_n = ~col_or_s;
  end

  assign reset_key = reset_key_q;
  assign evt_valid = evt_valid_q;
  assign evt_make  = evt_make_q;
  assign evt_row   = evt_row_q;
  assign evt_col   = evt_col_q;

endmodule

// File: tb/tb_ps2_matrix_mapper.sv
// Bench for ps2_matrix_mapper: directed steps plus random traffic against a scancode-level model.
module tb_ps2_matrix_mapper;

  localparam int ROWS  = 12;
  localparam int COLS  = 7;
  localparam int ROW_W = 4;
  localparam int COL_W = 3;
  localparam int PP    = 16;

  logic              clk;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_error;
  logic              map_we;
  logic [8:0]        map_addr;
  logic [7:0]        map_wdata;
  logic [ROWS-1:0]   row_sel_n;
  logic [COLS-1:0]   col_n;
  logic              reset_key;
  logic              evt_valid;
  logic              evt_make;
  logic [ROW_W-1:0]  evt_row;
  logic [COL_W-1:0]  evt_col;

  ps2_matrix_mapper #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .PAUSE_PULSE(PP)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata), .row_sel_n(row_sel_n),
    .col_n(col_n), .reset_key(reset_key), .evt_valid(evt_valid), .evt_make(evt_make),
    .evt_row(evt_row), .evt_col(evt_col)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  int rk_seen = 0;
  int evt_seen = 0;

  // Scancode-level model: key state, prefixes, bytes left to skip, pulse cycles left.
  logic [7:0] tbl [512];
  bit  m [ROWS][COLS];
  bit  m_ext, m_rel;
  int  pause_left, rk_left;
  bit  pend_v, pend_make;
  int  pend_r, pend_c;
  bit  exp_evt_v, exp_make;
  int  exp_row, exp_col;

  function automatic bit eff(int r, int c);
    bit v;
    v = m[r][c];
`ifdef PS2_MATRIX_GHOST_EN
    for (int r2 = 0; r2 < ROWS; r2++)
      for (int c2 = 0; c2 < COLS; c2++)
        if (r2 != r && c2 != c && m[r][c2] && m[r2][c2] && m[r2][c]) v = 1'b1;
`endif
    return v;
  endfunction

  function automatic logic [COLS-1:0] exp_cols();
    logic [COLS-1:0] res;
    for (int c = 0; c < COLS; c++) begin
      res[c] = 1'b1;
      for (int r = 0; r < ROWS; r++)
        if (!row_sel_n[r] && eff(r, c)) res[c] = 1'b0;
    end
    return res;
  endfunction

  task automatic clear_model_matrix();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = 1'b0;
  endtask

  // Apply this cycle's inputs to the model: a clear takes effect now, a key lands one cycle later.
  task automatic model_edge();
    bit clr, np_v, np_make;
    int np_r, np_c;
    logic [7:0] e;
    clr = 0; np_v = 0; np_make = 0; np_r = 0; np_c = 0;
    exp_evt_v = 0;
    if (reset) begin
      clear_model_matrix();
      m_ext = 0; m_rel = 0; pause_left = 0; rk_left = 0; pend_v = 0;
      exp_make = 0; exp_row = 0; exp_col = 0;
    end else begin
      if (rk_left > 0) rk_left--;
      if (rx_error) begin
        clr = 1; m_ext = 0; m_rel = 0; pause_left = 0;
      end else if (rx_valid) begin
        if (pause_left > 0) pause_left--;
        else if (rx_data == 8'hE0) m_ext = 1;
        else if (rx_data == 8'hF0) m_rel = 1;
        else if (rx_data == 8'hE1) begin pause_left = 7; rk_left = PP; end
        else if (rx_data == 8'hAA || rx_data == 8'h00 || rx_data == 8'hFF) begin
          clr = 1; m_ext = 0; m_rel = 0;
        end else begin
          e = tbl[{m_ext, rx_data}];
          np_r = int'(e[6:3]); np_c = int'(e[2:0]);
          np_v = e[7] && np_r < ROWS && np_c < COLS;
          np_make = !m_rel;
          m_ext = 0; m_rel = 0;
        end
      end
      if (clr) clear_model_matrix();
      else if (pend_v) begin
        m[pend_r][pend_c] = pend_make;
        exp_evt_v = 1; exp_make = pend_make; exp_row = pend_r; exp_col = pend_c;
      end
      pend_v = np_v; pend_r = np_r; pend_c = np_c; pend_make = np_make;
    end
    if (map_we) tbl[map_addr] = map_wdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("col_n", 32'(col_n), 32'(exp_cols()));
    chk("evt_valid", 32'(evt_valid), 32'(exp_evt_v));
    chk("evt_make", 32'(evt_make), 32'(exp_make));
    chk("evt_row", 32'(evt_row), 32'(exp_row));
    chk("evt_col", 32'(evt_col), 32'(exp_col));
    chk("reset_key", 32'(reset_key), 32'(rk_left > 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (reset_key) rk_seen++;
    if (evt_valid) evt_seen++;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
    cycle();
  endtask

  task automatic wr_map(input logic [8:0] a, input logic [7:0] d);
    map_we = 1'b1; map_addr = a; map_wdata = d;
    cycle();
    map_we = 1'b0;
  endtask

  function automatic logic [7:0] ent(input bit v, input int r, input int c);
    return {v, 4'(r), 3'(c)};
  endfunction

  function automatic logic [7:0] pick_code(input int k);
    case (k)
      0: return 8'h1C;  1: return 8'h12;  2: return 8'h75;  3: return 8'h15;
      4: return 8'h1D;  5: return 8'h24;  6: return 8'h14;  default: return 8'h77;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte();
    int k;
    k = $urandom_range(0, 19);
    case (k)
      0, 1:    return 8'hE0;
      2, 3:    return 8'hF0;
      4:       return 8'hE1;
      5:       return 8'hAA;
      6:       return ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      7:       return 8'($urandom);
      default: return pick_code(k % 8);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_g;
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0;
    map_we = 1'b0; map_addr = 9'd0; map_wdata = 8'd0; row_sel_n = '1;
    m_ext = 0; m_rel = 0; pause_left = 0; rk_left = 0; pend_v = 0;
    exp_evt_v = 0; exp_make = 0; exp_row = 0; exp_col = 0;
    clear_model_matrix();
    for (int a = 0; a < 512; a++) tbl[a] = 8'h00;
    @(negedge clk);

    // Table is RAM: zero it while held in reset.
    for (int a = 0; a < 512; a++) wr_map(9'(a), 8'h00);
    row_sel_n = '0;
    cycle();
    chk("rst_col_n", 32'(col_n), 32'h7F);
    chk("rst_evt", 32'({evt_valid, evt_make, evt_row, evt_col}), 32'd0);
    chk("rst_reset_key", 32'(reset_key), 32'd0);
    reset = 1'b0;
    cycle();

    // Single press and release.
    wr_map({1'b0, 8'h1C}, ent(1, 1, 5));
    row_sel_n = ~12'h002;
    send(8'h1C);
    chk("tp1_col", 32'(col_n), 32'b1011111);
    chk("tp1_evt", 32'({evt_valid, evt_make, evt_row, evt_col}), 32'({1'b1, 1'b1, 4'd1, 3'd5}));
    send(8'hF0); send(8'h1C);
    chk("tp1_rel_col", 32'(col_n), 32'h7F);
    chk("tp1_rel_make", 32'({evt_valid, evt_make}), 32'b10);

    // Two keys, two rows selected together.
    wr_map({1'b0, 8'h12}, ent(1, 0, 6));
    send(8'h1C); send(8'h12);
    row_sel_n = ~12'h003;
    cycle();
    chk("tp2_both", 32'(col_n), 32'b0011111);
    send(8'hF0); send(8'h12);
    chk("tp2_one", 32'(col_n), 32'b1011111);

    // Extended-only mapping.
    wr_map({1'b1, 8'h75}, ent(1, 9, 3));
    wr_map({1'b0, 8'h75}, ent(0, 9, 3));
    row_sel_n = ~12'h200;
    evt_seen = 0;
    send(8'h75);
    chk("tp3_noevt", 32'(evt_seen), 32'd0);
    chk("tp3_nochg", 32'(col_n), 32'h7F);
    send(8'hE0); send(8'h75);
    chk("tp3_ext", 32'(col_n), 32'b1110111);

    // Pause/Break: skipped bytes raise nothing, reset_key lasts PP cycles.
    wr_map({1'b0, 8'h14}, ent(1, 2, 2));
    wr_map({1'b0, 8'h77}, ent(1, 3, 3));
    row_sel_n = ~12'h002;
    send(8'hF0); send(8'h1C);
    rk_seen = 0; evt_seen = 0;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    for (int i = 0; i < 4; i++) cycle();
    chk("tp4_rk_len", 32'(rk_seen), 32'(PP));
    chk("tp4_noevt", 32'(evt_seen), 32'd0);
    send(8'h1C);
    chk("tp4_after", 32'(col_n), 32'b1011111);

    // Error strobe drops a pending F0 and clears all keys.
    send(8'hF0);
    rx_error = 1'b1; cycle(); rx_error = 1'b0;
    chk("tp5_err_clr", 32'(col_n), 32'h7F);
    send(8'h1C);
    chk("tp5_make", 32'({col_n, evt_make}), 32'({7'b1011111, 1'b1}));
    send(8'h12);
    row_sel_n = ~12'h003;
    send(8'hAA);
    chk("tp5_bat", 32'(col_n), 32'h7F);

    // Clear-all in the cycle a key write would land wins.
    rx_data = 8'h1C; rx_valid = 1'b1; cycle();
    rx_valid = 1'b0; rx_error = 1'b1; cycle(); rx_error = 1'b0;
    chk("clr_prio", 32'({evt_valid, col_n}), 32'({1'b0, 7'h7F}));
    cycle();

    // Same-cycle table write and lookup returns the old entry.
    rx_data = 8'h1C; rx_valid = 1'b1;
    map_we = 1'b1; map_addr = {1'b0, 8'h1C}; map_wdata = ent(1, 4, 4);
    cycle();
    rx_valid = 1'b0; map_we = 1'b0;
    cycle();
    chk("rdw_old", 32'({evt_row, evt_col}), 32'({4'd1, 3'd5}));
    send(8'h1C);
    chk("rdw_new", 32'({evt_row, evt_col}), 32'({4'd4, 3'd4}));
    send(8'hAA);

    // Ghost rectangle r0c0, r0c1, r1c0 seen from row 1.
    wr_map({1'b0, 8'h15}, ent(1, 0, 0));
    wr_map({1'b0, 8'h1D}, ent(1, 0, 1));
    wr_map({1'b0, 8'h24}, ent(1, 1, 0));
    send(8'h15); send(8'h1D); send(8'h24);
    row_sel_n = ~12'h002;
    cycle();
`ifdef PS2_MATRIX_GHOST_EN
    exp_g = 1'b0;
`else
    exp_g = 1'b1;
`endif
    chk("ghost_c1", 32'(col_n[1]), 32'(exp_g));
    chk("ghost_c0", 32'(col_n[0]), 32'd0);

    // Random traffic, including back-to-back bytes, bad entries and resets.
    for (int i = 0; i < 2500; i++) begin
      reset     = ($urandom_range(0, 499) == 0);
      rx_error  = ($urandom_range(0, 59) == 0);
      rx_valid  = ($urandom_range(0, 2) == 0);
      rx_data   = pick_byte();
      map_we    = ($urandom_range(0, 9) == 0);
      map_addr  = {1'($urandom_range(0, 1)), pick_code($urandom_range(0, 7))};
      map_wdata = {1'($urandom_range(0, 3) != 0), 7'($urandom)};
      if ($urandom_range(0, 7) == 0) row_sel_n = 12'($urandom);
      cycle();
    end
    reset = 1'b0; rx_error = 1'b0; rx_valid = 1'b0; map_we = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
